// File: rtl/alu_result_accumulator_pkg.sv
// Shared FSM encoding and default widths for the ALU result accumulator.
package alu_result_accumulator_pkg;

    localparam int DATA_W    = 8;
    localparam int B_W       = 4;
    localparam int CNT_W     = 4;
    localparam int CARRY_BIT = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_PRESENT = 2'd2
    } acc_state_e;

endpackage

// File: rtl/alu_result_accumulator_acc_capture_counter.sv
// Wrapping up/down capture counter; clear beats inc, inc beats dec.
module acc_capture_counter #(
    parameter int CNT_W = alu_result_accumulator_pkg::CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)      cnt_d = '0;
        else if (inc_i) cnt_d = cnt_q + 1'b1;
        else if (dec_i) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/alu_result_accumulator.sv
// Captures ALU results, feeds the low bits back as operand B, handshakes both sides.
// Optional one-deep undo of the last capture when ALU_ACC_UNDO_EN is defined.
module alu_result_accumulator #(
    parameter int DATA_W    = alu_result_accumulator_pkg::DATA_W,
    parameter int B_W       = alu_result_accumulator_pkg::B_W,
    parameter int CNT_W     = alu_result_accumulator_pkg::CNT_W,
    parameter int CARRY_BIT = alu_result_accumulator_pkg::CARRY_BIT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              clear_i,
`ifdef ALU_ACC_UNDO_EN
    input  logic              undo_i,
`endif
    output logic [B_W-1:0]    b_out_o,
    output logic [DATA_W-1:0] q_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CNT_W-1:0]  acc_count_o,
    output logic              carry_sticky_o
);

    import alu_result_accumulator_pkg::*;

    acc_state_e        state_q, state_d;
    logic [DATA_W-1:0] q_q, q_d;
    logic              sticky_q, sticky_d;
    logic              capture;
    logic              undo_do;

    assign capture = (state_q == ST_IDLE) && in_valid_i && !clear_i;

`ifdef ALU_ACC_UNDO_EN
    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic              shadow_vld_q, shadow_vld_d;

    // Capture takes precedence over a coincident undo.
    assign undo_do = (state_q == ST_IDLE) && undo_i && shadow_vld_q
                     && !in_valid_i && !clear_i;

    always_comb begin
        shadow_d     = shadow_q;
        shadow_vld_d = shadow_vld_q;
        if (clear_i) begin
            shadow_vld_d = 1'b0;
        end else if (capture) begin
            shadow_d     = q_q;
            shadow_vld_d = 1'b1;
        end else if (undo_do) begin
            shadow_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow_q     <= '0;
            shadow_vld_q <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            shadow_vld_q <= shadow_vld_d;
        end
    end
`else
    assign undo_do = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        sticky_d = sticky_q;
        if (clear_i) begin
            state_d  = ST_IDLE;
            q_d      = '0;
            sticky_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (capture) begin
                        q_d      = alu_result_i;
                        sticky_d = sticky_q | alu_result_i[CARRY_BIT];
                        state_d  = ST_SETTLE;
                    end
`ifdef ALU_ACC_UNDO_EN
                    else if (undo_do) begin
                        q_d = shadow_q;
                    end
`endif
                end
                ST_SETTLE:  state_d = ST_PRESENT;
                ST_PRESENT: if (out_ready_i) state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            q_q      <= '0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            sticky_q <= sticky_d;
        end
    end

    acc_capture_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clear_i),
        .inc_i (capture),
        .dec_i (undo_do),
        .cnt_o (acc_count_o)
    );

    // b_out comes straight from the register, so the ALU loop is always broken by a flop.
    assign b_out_o        = q_q[B_W-1:0];
    assign q_o            = q_q;
    assign in_ready_o     = (state_q == ST_IDLE);
    assign out_valid_o    = (state_q == ST_PRESENT);
    assign carry_sticky_o = sticky_q;

endmodule

// File: tb/tb_alu_result_accumulator.sv
// Directed bench for alu_result_accumulator; undo checks run when ALU_ACC_UNDO_EN is defined.
module tb_alu_result_accumulator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] alu_result = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       clear = 1'b0;
    logic       undo = 1'b0;
    logic [3:0] b_out;
    logic [7:0] q;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] acc_count;
    logic       carry_sticky;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_result_accumulator dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .alu_result_i   (alu_result),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .clear_i        (clear),
`ifdef ALU_ACC_UNDO_EN
        .undo_i         (undo),
`endif
        .b_out_o        (b_out),
        .q_o            (q),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .acc_count_o    (acc_count),
        .carry_sticky_o (carry_sticky)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Full capture with out_ready high: IDLE -> SETTLE -> PRESENT -> IDLE.
    task automatic capture(input logic [7:0] v);
        alu_result = v;
        in_valid   = 1'b1;
        tick();
        in_valid   = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        // reset held 2 cycles
        tick();
        tick();
        chk("rst_q", q, 8'h00);
        chk("rst_b", b_out, 4'h0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_cnt", acc_count, 4'd0);
        chk("rst_sticky", carry_sticky, 1'b0);
        rst = 1'b0;

        // basic capture of 0x13 and latency
        alu_result = 8'h13;
        in_valid   = 1'b1;
        tick();
        in_valid   = 1'b0;
        chk("cap_q", q, 8'h13);
        chk("cap_b", b_out, 4'h3);
        chk("cap_sticky", carry_sticky, 1'b1);
        chk("cap_in_ready", in_ready, 1'b0);
        chk("settle_out_valid", out_valid, 1'b0);
        tick();
        chk("present_out_valid", out_valid, 1'b1);
        tick();
        chk("idle_in_ready", in_ready, 1'b1);
        chk("cap_cnt", acc_count, 4'd1);

        // backpressure: 0x0F pulses during PRESENT are not captured
        do_clear();
        out_ready  = 1'b0;
        alu_result = 8'h05;
        in_valid   = 1'b1;
        tick();
        in_valid   = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            alu_result = 8'h0F;
            in_valid   = i[0];
            tick();
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_q", q, 8'h05);
            chk("bp_cnt", acc_count, 4'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release_in_ready", in_ready, 1'b1);
        chk("bp_release_q", q, 8'h05);

        // 16 captures of 0x01 wrap the counter
        do_clear();
        for (int i = 0; i < 16; i++) begin
            capture(8'h01);
            if (i == 0) chk("wrap_cnt_first", acc_count, 4'd1);
            if (i == 14) chk("wrap_cnt_15", acc_count, 4'd15);
        end
        chk("wrap_cnt", acc_count, 4'd0);
        chk("wrap_sticky", carry_sticky, 1'b0);
        chk("wrap_q", q, 8'h01);

        // clear during PRESENT, with a coincident in_valid that must be discarded
        do_clear();
        out_ready  = 1'b0;
        alu_result = 8'h1A;
        in_valid   = 1'b1;
        tick();
        in_valid   = 1'b0;
        tick();
        chk("clr_pre_out_valid", out_valid, 1'b1);
        chk("clr_pre_sticky", carry_sticky, 1'b1);
        clear      = 1'b1;
        alu_result = 8'h33;
        in_valid   = 1'b1;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("clr_q", q, 8'h00);
        chk("clr_out_valid", out_valid, 1'b0);
        chk("clr_cnt", acc_count, 4'd0);
        chk("clr_sticky", carry_sticky, 1'b0);
        chk("clr_in_ready", in_ready, 1'b1);
        tick();
        chk("clr_no_capture_q", q, 8'h00);
        chk("clr_no_capture_cnt", acc_count, 4'd0);

        // reset mid-SETTLE wipes the partial capture
        alu_result = 8'h91;
        in_valid   = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("mid_q", q, 8'h91);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_q", q, 8'h00);
        chk("mid_rst_cnt", acc_count, 4'd0);
        chk("mid_rst_sticky", carry_sticky, 1'b0);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        tick();
        chk("mid_rst_out_valid", out_valid, 1'b0);

        // high bits stored verbatim, sticky from bit 4 only
        capture(8'hE7);
        chk("raw_q", q, 8'hE7);
        chk("raw_b", b_out, 4'h7);
        chk("raw_sticky", carry_sticky, 1'b0);

`ifdef ALU_ACC_UNDO_EN
        do_clear();
        capture(8'h02);
        capture(8'h07);
        chk("undo_pre_q", q, 8'h07);
        chk("undo_pre_cnt", acc_count, 4'd2);
        undo = 1'b1;
        tick();
        undo = 1'b0;
        chk("undo_q", q, 8'h02);
        chk("undo_cnt", acc_count, 4'd1);
        undo = 1'b1;
        tick();
        undo = 1'b0;
        chk("undo2_q", q, 8'h02);
        chk("undo2_cnt", acc_count, 4'd1);
        // undo with in_valid: capture wins
        alu_result = 8'h04;
        in_valid   = 1'b1;
        undo       = 1'b1;
        tick();
        in_valid = 1'b0;
        undo     = 1'b0;
        chk("undo_vs_cap_q", q, 8'h04);
        chk("undo_vs_cap_cnt", acc_count, 4'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
